signal_detect_mc: RTL and testbench
===================================

# signal_detect_mc

Multi-channel run-length symbol detector; the next generation of the single-channel signal detector. Per channel it counts consecutive equal valid beats and emits a decoded symbol when the run matches the thresholds. It adds runtime-programmable thresholds, run-length reporting, short/long pulse error flags, counter saturation, and optional per-channel error counters. It sits between line samplers (PWM or one-wire-timing inputs) and the protocol decoders.

## Interface
- CH_NUM, 4, number of independent channels
- CNT_W, 10, run counter width
- MODE, 1, 0: PWM (symbol on level change), 1: OWT (symbol when run reaches DN threshold)
- ERR_CNT_W, 8, error counter width (used only with SIGNAL_DETECT_MC_ERR_CNT_EN)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_en  in  1  global enable; low clears all channel state synchronously
- i_dn_th  in  CNT_W  lower run threshold, shared; quasi-static, change only while i_en=0
- i_up_th  in  CNT_W  upper run threshold, PWM only; must be < 2^CNT_W-1
- i_vld  in  CH_NUM  per-channel sample valid
- i_vld_data  in  CH_NUM  per-channel sample value
- o_vld  out  CH_NUM  symbol pulse
- o_vld_data  out  CH_NUM  symbol value
- o_len  out  CH_NUM*CNT_W  run length of emitted symbol, channel c at [c*CNT_W +: CNT_W]
- o_err_short  out  CH_NUM  run ended below DN threshold
- o_err_long  out  CH_NUM  run exceeded UP threshold (PWM)
- i_err_clr  in  1  clear error counters (macro only)
- o_err_cnt  out  CH_NUM*ERR_CNT_W  per-channel error count (macro only)

## Operation
- Per channel state: cnt (run length k of the current run), last_data. Effective DN = max(i_dn_th, 1).
- i_vld=0 on a cycle: run aborted, cnt<=0, no symbol, no error.
- i_vld=1, cnt==0: new run, cnt<=1, last_data<=data.
- i_vld=1, data==last_data, cnt!=0: cnt<=cnt+1. The counter saturates at 2^CNT_W-1.
- i_vld=1, data!=last_data, cnt!=0: previous run is evaluated, then cnt<=1 and last_data<=data.
- OWT: on a beat where the updated k equals DN, emit data with o_len=DN and set cnt<=0. On a change with 0<cnt<DN, assert err_short. UP is ignored.
- PWM, evaluation on change:
  - DN<=cnt<=UP: emit last_data with o_len=cnt.
  - 0<cnt<DN: assert err_short.
  - cnt==UP+1: no emit and no error, because the long error was already flagged.
- PWM long run: on the continue beat where k becomes UP+1, assert err_long once. cnt then holds at UP+1 until change or abort.
- PWM with DN>UP: no symbols are emitted; runs produce only short or long errors.
- Channels are fully independent. Symbol and error are mutually exclusive per channel per cycle.

## Timing
- All outputs registered. Response appears exactly 1 cycle after the triggering beat.
- Pulses (o_vld, o_err_*) last 1 cycle. o_vld_data and o_len are valid only with o_vld and are 0 otherwise.
- Reset: every output 0, cnt 0, last_data 0, error counters 0.
- i_en=0 at cycle N: no output at N+1, and state is cleared.
- Reset asserted mid-run: run discarded with no output; the next valid beat starts a new run.
- Throughput: one beat per channel per cycle.

## Configuration
- SIGNAL_DETECT_MC_ERR_CNT_EN defined:
  - Each channel has an ERR_CNT_W saturating counter, incremented by 1 on each err_short or err_long pulse.
  - i_err_clr=1 clears all counters next cycle. Clear has priority over a same-cycle event, so the result is 0.
- Not defined: i_err_clr and o_err_cnt ports are absent and no counter logic exists.

## Test plan
- OWT, DN=4, ch0 data 1 for 4 beats: o_vld[0]=1, o_vld_data=1, o_len=4 one cycle after the 4th beat. A 5th beat with data 1 starts a new run.
- OWT, DN=4, ch1 data 0,0,1: o_err_short[1] one cycle after the third beat, no o_vld.
- PWM, DN=4, UP=8, ch2 data 1×6 then 0: o_vld=1, data=1, o_len=6 after the 0 beat.
- PWM, UP=8, ch3 data 1×12 then 0: single o_err_long after the 9th beat. Nothing is emitted at the change.
- PWM, all channels stimulated simultaneously with different runs, with i_vld dropped for one cycle mid-run on ch0: independent responses, and ch0 aborts silently.
- Macro on: three short errors on ch0, then i_err_clr together with a 4th error: o_err_cnt[0] reads 3, then 0.

Source files
------------

// File: rtl/signal_detect_mc.sv
// Multi-channel run-length symbol detector (PWM / OWT). Optional per-channel
// saturating error counters are built when SIGNAL_DETECT_MC_ERR_CNT_EN is defined.
module signal_detect_mc_lane #(
  parameter int CNT_W     = 10,
  parameter int MODE      = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_dn,
  input  logic [CNT_W-1:0] i_up_th,
  input  logic             i_vld,
  input  logic             i_data,
`ifdef SIGNAL_DETECT_MC_ERR_CNT_EN
  input  logic                 i_err_clr,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
`endif
  output logic             o_vld,
  output logic             o_data,
  output logic [CNT_W-1:0] o_len,
  output logic             o_err_short,
  output logic             o_err_long
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d, inc, k;
  logic             last_q, last_d;
  logic             vld_d, data_d, es_d, el_d;
  logic [CNT_W-1:0] len_d;

  assign inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign k   = (cnt_q == '0) ? CNT_W'(1) : inc;

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    vld_d  = 1'b0;
    data_d = 1'b0;
    len_d  = '0;
    es_d   = 1'b0;
    el_d   = 1'b0;
    if (!i_en) begin
      cnt_d  = '0;
      last_d = 1'b0;
    end else if (!i_vld) begin
      cnt_d = '0;
    end else if (cnt_q == '0 || i_data == last_q) begin
      last_d = i_data;
      if (MODE == 1) begin
        cnt_d = k;
        if (k == i_dn) begin
          vld_d  = 1'b1;
          data_d = i_data;
          len_d  = k;
          cnt_d  = '0;
        end
      end else if (cnt_q == '0) begin
        cnt_d = k;
      end else if (cnt_q <= i_up_th) begin
        // crossing UP flags long once; afterwards the count parks at UP+1
        cnt_d = inc;
        el_d  = (cnt_q == i_up_th);
      end
    end else begin
      if (MODE == 1) begin
        es_d = (cnt_q < i_dn);
      end else if (cnt_q <= i_up_th) begin
        if (cnt_q < i_dn) begin
          es_d = 1'b1;
        end else begin
          vld_d  = 1'b1;
          data_d = last_q;
          len_d  = cnt_q;
        end
      end
      cnt_d  = CNT_W'(1);
      last_d = i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q       <= '0;
      last_q      <= 1'b0;
      o_vld       <= 1'b0;
      o_data      <= 1'b0;
      o_len       <= '0;
      o_err_short <= 1'b0;
      o_err_long  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      o_vld       <= vld_d;
      o_data      <= data_d;
      o_len       <= len_d;
      o_err_short <= es_d;
      o_err_long  <= el_d;
    end
  end

`ifdef SIGNAL_DETECT_MC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] ecnt_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                  ecnt_q <= '0;
    else if (i_err_clr)                         ecnt_q <= '0;
    else if ((es_d || el_d) && ecnt_q != '1)    ecnt_q <= ecnt_q + 1'b1;
  end
  assign o_err_cnt = ecnt_q;
`endif
endmodule

module signal_detect_mc #(
  parameter int CH_NUM    = 4,
  parameter int CNT_W     = 10,
  parameter int MODE      = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [CNT_W-1:0]        i_dn_th,
  input  logic [CNT_W-1:0]        i_up_th,
  input  logic [CH_NUM-1:0]       i_vld,
  input  logic [CH_NUM-1:0]       i_vld_data,
`ifdef SIGNAL_DETECT_MC_ERR_CNT_EN
  input  logic                    i_err_clr,
  output logic [CH_NUM*ERR_CNT_W-1:0] o_err_cnt,
`endif
  output logic [CH_NUM-1:0]       o_vld,
  output logic [CH_NUM-1:0]       o_vld_data,
  output logic [CH_NUM*CNT_W-1:0] o_len,
  output logic [CH_NUM-1:0]       o_err_short,
  output logic [CH_NUM-1:0]       o_err_long
);
  // a zero DN threshold behaves as one
  logic [CNT_W-1:0] dn_eff;
  assign dn_eff = (i_dn_th == '0) ? CNT_W'(1) : i_dn_th;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_lane
    signal_detect_mc_lane #(.CNT_W(CNT_W), .MODE(MODE), .ERR_CNT_W(ERR_CNT_W)) u_lane (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_en        (i_en),
      .i_dn        (dn_eff),
      .i_up_th     (i_up_th),
      .i_vld       (i_vld[c]),
      .i_data      (i_vld_data[c]),
`ifdef SIGNAL_DETECT_MC_ERR_CNT_EN
      .i_err_clr   (i_err_clr),
      .o_err_cnt   (o_err_cnt[c*ERR_CNT_W +: ERR_CNT_W]),
`endif
      .o_vld       (o_vld[c]),
      .o_data      (o_vld_data[c]),
      .o_len       (o_len[c*CNT_W +: CNT_W]),
      .o_err_short (o_err_short[c]),
      .o_err_long  (o_err_long[c])
    );
  end
endmodule

// File: tb/tb_signal_detect_mc.sv
// Bench for signal_detect_mc: a PWM and an OWT instance share stimulus and are
// compared against a run-length reference model (plus directed scenarios).
module tb_signal_detect_mc;
  localparam int CH = 4, W = 10, EW = 8, VW = 4*CH + CH*W;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, err_clr = 1'b0;
  logic [W-1:0] dn = '0, up = '0;
  logic [CH-1:0] vld = '0, vdat = '0;

  logic [CH-1:0] p_vld, p_dat, p_es, p_el, t_vld, t_dat, t_es, t_el;
  logic [CH*W-1:0] p_len, t_len;
  logic [CH*EW-1:0] p_ecnt, t_ecnt;

  always #5 clk = ~clk;

  signal_detect_mc #(.CH_NUM(CH), .CNT_W(W), .MODE(0), .ERR_CNT_W(EW)) u_pwm (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_dn_th(dn), .i_up_th(up),
    .i_vld(vld), .i_vld_data(vdat),
`ifdef SIGNAL_DETECT_MC_ERR_CNT_EN
    .i_err_clr(err_clr), .o_err_cnt(p_ecnt),
`endif
    .o_vld(p_vld), .o_vld_data(p_dat), .o_len(p_len),
    .o_err_short(p_es), .o_err_long(p_el));

  signal_detect_mc #(.CH_NUM(CH), .CNT_W(W), .MODE(1), .ERR_CNT_W(EW)) u_owt (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_dn_th(dn), .i_up_th(up),
    .i_vld(vld), .i_vld_data(vdat),
`ifdef SIGNAL_DETECT_MC_ERR_CNT_EN
    .i_err_clr(err_clr), .o_err_cnt(t_ecnt),
`endif
    .o_vld(t_vld), .o_vld_data(t_dat), .o_len(t_len),
    .o_err_short(t_es), .o_err_long(t_el));

`ifndef SIGNAL_DETECT_MC_ERR_CNT_EN
  assign p_ecnt = '0;
  assign t_ecnt = '0;
`endif

  logic [VW-1:0] got [2];
  assign got[0] = {p_vld, p_dat, p_len, p_es, p_el};
  assign got[1] = {t_vld, t_dat, t_len, t_es, t_el};

  int checks = 0, passes = 0;

  // reference model: index 0 = PWM, 1 = OWT; run length kept unbounded
  int mk [2][CH];
  bit mlast [2][CH];
  int ecnt [2][CH];
  logic [CH-1:0] ev [2], ed [2], es [2], el [2];
  logic [CH*W-1:0] elen [2];

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      ev[m] = '0; ed[m] = '0; es[m] = '0; el[m] = '0; elen[m] = '0;
      for (int c = 0; c < CH; c++) begin mk[m][c] = 0; mlast[m][c] = 0; ecnt[m][c] = 0; end
    end
  endfunction

  function automatic void model_step();
    int dne, upi;
    bit d;
    dne = (dn == 0) ? 1 : int'(dn);
    upi = int'(up);
    for (int m = 0; m < 2; m++) begin
      ev[m] = '0; ed[m] = '0; es[m] = '0; el[m] = '0; elen[m] = '0;
      for (int c = 0; c < CH; c++) begin
        d = vdat[c];
        if (!en) begin
          mk[m][c] = 0; mlast[m][c] = 0;
        end else if (!vld[c]) begin
          mk[m][c] = 0;
        end else if (mk[m][c] == 0 || d == mlast[m][c]) begin
          if (mk[m][c] == 0) mk[m][c] = 1;
          else begin
            mk[m][c]++;
            if (m == 0 && mk[m][c] == upi + 1) el[m][c] = 1'b1;
          end
          mlast[m][c] = d;
          if (m == 1 && mk[m][c] == dne) begin
            ev[m][c] = 1'b1; ed[m][c] = d; elen[m][c*W +: W] = W'(dne); mk[m][c] = 0;
          end
        end else begin
          if (m == 1) es[m][c] = 1'b1;
          else if (mk[m][c] > upi) ;
          else if (mk[m][c] < dne) es[m][c] = 1'b1;
          else begin
            ev[m][c] = 1'b1; ed[m][c] = mlast[m][c]; elen[m][c*W +: W] = W'(mk[m][c]);
          end
          mk[m][c] = 1; mlast[m][c] = d;
        end
        if (err_clr) ecnt[m][c] = 0;
        else if ((es[m][c] || el[m][c]) && ecnt[m][c] < (1 << EW) - 1) ecnt[m][c]++;
      end
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec(int m);
    return {ev[m], ed[m], elen[m], es[m], el[m]};
  endfunction

  // one clock with the given inputs; returns #1 after the edge
  task automatic drive(input logic e, input logic [CH-1:0] v, input logic [CH-1:0] d);
    en = e; vld = v; vdat = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (got[m] !== '0) $display("FAIL reset_outputs mode%0d got=%h exp=0", m, got[m]);
      else passes++;
    end
    checks++;
    if ({p_ecnt, t_ecnt} !== '0) $display("FAIL reset_errcnt got=%h exp=0", {p_ecnt, t_ecnt});
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_owt_symbol();
    dn = W'(4); up = W'(8);
    idle();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'b0001, 4'b0001);
      if (i == 4) begin
        checks++;
        if (t_vld[0] !== 1'b1 || t_dat[0] !== 1'b1 || t_len[0 +: W] !== W'(4))
          $display("FAIL owt_symbol vld=%b data=%b len=%0d exp vld=1 data=1 len=4",
                   t_vld[0], t_dat[0], t_len[0 +: W]);
        else passes++;
      end
      if (i == 5) begin
        checks++;
        if (t_vld !== '0 || t_es !== '0)
          $display("FAIL owt_fifth_beat vld=%b es=%b exp 0", t_vld, t_es);
        else passes++;
      end
    end
  endtask

  task automatic test_owt_short();
    dn = W'(4);
    idle();
    drive(1'b1, 4'b0010, 4'b0000);
    drive(1'b1, 4'b0010, 4'b0000);
    drive(1'b1, 4'b0010, 4'b0010);
    checks++;
    if (t_es !== 4'b0010 || t_vld !== '0)
      $display("FAIL owt_short es=%b vld=%b exp es=0010 vld=0000", t_es, t_vld);
    else passes++;
  endtask

  task automatic test_pwm_symbol();
    dn = W'(4); up = W'(8);
    idle();
    repeat (6) drive(1'b1, 4'b0100, 4'b0100);
    drive(1'b1, 4'b0100, 4'b0000);
    checks++;
    if (p_vld !== 4'b0100 || p_dat !== 4'b0100 || p_len[2*W +: W] !== W'(6) || p_es !== '0)
      $display("FAIL pwm_symbol vld=%b data=%b len=%0d exp vld=0100 data=0100 len=6",
               p_vld, p_dat, p_len[2*W +: W]);
    else passes++;
  endtask

  task automatic test_pwm_long();
    int nlong;
    dn = W'(4); up = W'(8);
    idle();
    nlong = 0;
    for (int i = 1; i <= 13; i++) begin
      drive(1'b1, 4'b1000, (i <= 12) ? 4'b1000 : 4'b0000);
      if (p_el[3]) nlong++;
      if (i == 9) begin
        checks++;
        if (p_el !== 4'b1000) $display("FAIL pwm_long_at_9 el=%b exp 1000", p_el);
        else passes++;
      end
      if (i == 13) begin
        checks++;
        if (p_vld !== '0 || p_es !== '0 || p_el !== '0)
          $display("FAIL pwm_long_change vld=%b es=%b el=%b exp all 0", p_vld, p_es, p_el);
        else passes++;
      end
    end
    checks++;
    if (nlong != 1) $display("FAIL pwm_long_count got=%0d exp=1", nlong);
    else passes++;
  endtask

  task automatic test_multi_channel();
    logic [CH-1:0] v, d;
    dn = W'(4); up = W'(8);
    idle();
    for (int t = 0; t < 14; t++) begin
      v = 4'b1111; v[0] = (t != 3);
      d[0] = (t < 3) ? 1'b1 : (t < 9 ? 1'b0 : 1'b1);
      d[1] = (t >= 5);
      d[2] = (t < 2);
      d[3] = (t < 10);
      drive(1'b1, v, d);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (got[m] !== exp_vec(m))
          $display("FAIL multi t=%0d mode%0d got=%h exp=%h", t, m, got[m], exp_vec(m));
        else passes++;
      end
      if (t == 3) begin
        checks++;
        if (p_vld[0] | p_es[0] | p_el[0] | t_vld[0] | t_es[0])
          $display("FAIL multi_abort got pulse on ch0 exp none");
        else passes++;
      end
    end
  endtask

  task automatic test_reset_midrun();
    dn = W'(4); up = W'(8);
    idle();
    repeat (3) drive(1'b1, 4'b1111, 4'b0101);
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (got[m] !== '0) $display("FAIL midrun_reset mode%0d got=%h exp=0", m, got[m]);
      else passes++;
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b1111, (i < 4) ? 4'b0101 : 4'b1010);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (got[m] !== exp_vec(m))
          $display("FAIL after_reset i=%0d mode%0d got=%h exp=%h", i, m, got[m], exp_vec(m));
        else passes++;
      end
    end
  endtask

  task automatic test_random();
    logic [CH-1:0] v, d;
    logic e;
    d = '0;
    for (int cfg = 0; cfg < 8; cfg++) begin
      dn = W'($urandom_range(0, 6));
      up = W'($urandom_range(0, 10));
      idle();
      for (int t = 0; t < 200; t++) begin
        e = ($urandom_range(0, 99) != 0);
        for (int c = 0; c < CH; c++) begin
          v[c] = ($urandom_range(0, 19) != 0);
          if ($urandom_range(0, 4) == 0) d[c] = ~d[c];
        end
        drive(e, v, d);
        for (int m = 0; m < 2; m++) begin
          checks++;
          if (got[m] !== exp_vec(m))
            $display("FAIL random cfg=%0d t=%0d mode%0d dn=%0d up=%0d got=%h exp=%h",
                     cfg, t, m, dn, up, got[m], exp_vec(m));
          else passes++;
        end
      end
    end
  endtask

`ifdef SIGNAL_DETECT_MC_ERR_CNT_EN
  task automatic test_err_cnt();
    dn = W'(4); up = W'(8);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 4'b0001, (i % 2 == 0) ? 4'b0001 : 4'b0000);
    checks++;
    if (p_ecnt[0 +: EW] !== EW'(3) || t_ecnt[0 +: EW] !== EW'(3))
      $display("FAIL err_cnt_three pwm=%0d owt=%0d exp=3", p_ecnt[0 +: EW], t_ecnt[0 +: EW]);
    else passes++;
    err_clr = 1'b1;
    drive(1'b1, 4'b0001, 4'b0001);
    err_clr = 1'b0;
    checks++;
    if (p_ecnt[0 +: EW] !== '0 || t_ecnt[0 +: EW] !== '0)
      $display("FAIL err_cnt_clear pwm=%0d owt=%0d exp=0", p_ecnt[0 +: EW], t_ecnt[0 +: EW]);
    else passes++;
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, 4'($urandom), 4'($urandom));
      for (int c = 0; c < CH; c++) begin
        checks++;
        if (p_ecnt[c*EW +: EW] !== EW'(ecnt[0][c]) || t_ecnt[c*EW +: EW] !== EW'(ecnt[1][c]))
          $display("FAIL err_cnt_rand ch%0d pwm=%0d/%0d owt=%0d/%0d", c,
                   p_ecnt[c*EW +: EW], ecnt[0][c], t_ecnt[c*EW +: EW], ecnt[1][c]);
        else passes++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_owt_symbol();
    test_owt_short();
    test_pwm_symbol();
    test_pwm_long();
    test_multi_channel();
    test_reset_midrun();
    test_random();
`ifdef SIGNAL_DETECT_MC_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
